note_event_scheduler: RTL
=========================

NOTE_EVENT_SCHEDULER -- requirements
Module: note_event_scheduler

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, chart ROM address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have parameter LATE_WINDOW, default 29'd100000, late-drop threshold in microseconds.
REQ-004 clk  input  1  system clock.
REQ-005 resetn  input  1  reset, asynchronous, active-high.
REQ-006 us_time  input  29  microsecond count from the upstream time counter; wraps 300000000 -> 0.
REQ-007 start  input  1  one-cycle pulse; begins chart playback at ROM address 0.
REQ-008 rom_addr  output  ADDR_BITS  chart ROM read address.
REQ-009 rom_data  input  32  chart word: [31] end marker, [30:29] lane, [28:0] timestamp in us.
REQ-010 ev_valid  output  1  event available at FIFO head.
REQ-011 ev_ready  input  1  consumer accepts the head event.
REQ-012 ev_lane  output  2  lane of the head event.
REQ-013 ev_time  output  29  timestamp of the head event.
REQ-014 busy  output  1  high in FETCH, WAIT and ARMED.
REQ-015 done  output  1  high in DONE.
REQ-016 wrapped  output  1  sticky; chart aborted by a us_time wrap.
REQ-017 late_count  output  8  saturating count of dropped late events (LATE_DROP_EN only, else constant 0).

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, WAIT, ARMED and DONE.
REQ-019 IDLE or DONE + start -> FETCH, rom_addr=0, FIFO flushed, wrapped and late_count cleared; start SHALL be ignored in any other state.
REQ-020 FETCH drives rom_addr; the next cycle is WAIT (ROM latency is 1 cycle); in WAIT rom_data SHALL be registered into the pending word and the state SHALL go to ARMED.
REQ-021 ARMED with end marker=1 SHALL go to DONE without pushing.
REQ-022 ARMED with us_time >= pending timestamp and a free FIFO slot SHALL push {lane, timestamp}, increment rom_addr, and go to FETCH in the same cycle.
REQ-023 ARMED with a due event and a full FIFO SHALL hold (stall) with no push and no address change.
REQ-024 A push into a full FIFO SHALL be accepted when ev_ready and ev_valid are both high in the same cycle (pop first).
REQ-025 rom_addr at its maximum value after a push SHALL wrap to 0 and the state SHALL go to DONE.
REQ-026 The block SHALL sample us_time every cycle; in FETCH, WAIT or ARMED, us_time lower than the previous sample SHALL set wrapped=1 and go to DONE, with FIFO contents retained.
REQ-027 ev_valid SHALL equal FIFO not-empty; ev_lane and ev_time SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-028 Event order out SHALL equal chart order; no event SHALL be duplicated or lost except by REQ-034.
REQ-029 Push-to-ev_valid latency SHALL be 1 cycle into an empty FIFO.

Reset
REQ-030 resetn=1 SHALL immediately force state IDLE and clear the FIFO pointers.
REQ-031 During reset rom_addr=0, ev_valid=0, ev_lane=0, ev_time=0, busy=0, done=0, wrapped=0, late_count=0.
REQ-032 Reset asserted mid-chart SHALL discard all queued events; after release no event SHALL be emitted until the next start.

Configuration
REQ-033 Macro LATE_DROP_EN SHALL select late-event handling.
REQ-034 With LATE_DROP_EN defined, an ARMED event with us_time - timestamp > LATE_WINDOW SHALL be skipped with no push; rom_addr SHALL increment and late_count SHALL increment, saturating at 255.
REQ-035 Without LATE_DROP_EN, late events SHALL be pushed like any due event, and late_count SHALL be tied to 0.

Verification
REQ-036 Chart {ts 10 lane1, ts 20 lane2, END}, us_time ramping from 0, ev_ready=1 -> events (1,10) and (2,20) emitted at us_time>=10 and >=20, then done=1.
REQ-037 Chart of 6 events with ts=0, ev_ready=0 -> 4 events queued, ARMED stall at rom_addr=4; ev_ready=1 -> 6 events in order.
REQ-038 Full FIFO, ev_ready=1 in the cycle the 5th event is due -> pop and push in the same cycle, occupancy stays 4.
REQ-039 us_time 299999990 -> 0 while ARMED -> wrapped=1, done=1, queued events still delivered.
REQ-040 LATE_DROP_EN defined, us_time=500000 at start, chart ts 100 and 450000 -> first event dropped, late_count=1, second emitted; macro undefined -> both emitted.
REQ-041 resetn pulse with 3 events queued -> ev_valid=0 and state IDLE immediately; nothing emitted until start.

Source files
------------

// File: rtl/note_event_scheduler_if.sv
// Event stream from the scheduler to the note consumer: valid/ready handshake
// carrying the lane and timestamp of the event at the queue head.
interface note_event_scheduler_if;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_lane;
  logic [28:0] ev_time;

  modport master (output ev_valid, output ev_lane, output ev_time, input ev_ready);
  modport slave  (input ev_valid, input ev_lane, input ev_time, output ev_ready);
endinterface

// File: rtl/note_event_scheduler.sv
// Chart playback: fetches chart words from a 1-cycle ROM and queues each event into a FIFO once us_time reaches it.
// Optional macro LATE_DROP_EN skips events older than LATE_WINDOW and counts them in late_count.
module note_event_scheduler #(
  parameter int          ADDR_BITS   = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [28:0] LATE_WINDOW = 29'd100000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [28:0]          us_time,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [31:0]          rom_data,
  note_event_scheduler_if.master ev,
  output logic                 busy,
  output logic                 done,
  output logic                 wrapped,
  output logic [7:0]           late_count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ARMED, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_pend;
  logic [28:0]          r_prev;
  logic                 r_wrapped;
  logic [30:0]          r_mem [FIFO_DEPTH];
  logic [PW:0]          r_wptr;
  logic [PW:0]          r_rptr;
  logic [30:0]          w_head;
  logic                 w_empty, w_full, w_pop, w_room;
  logic                 w_push, w_skip, w_adv, w_start;
  logic                 w_run, w_wrap, w_due, w_late, w_addr_max;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
  assign w_pop      = !w_empty && ev.ev_ready;
  // A pop in the same cycle frees the slot for the push.
  assign w_room     = !w_full || w_pop;
  assign w_due      = (us_time >= r_pend[28:0]);
  assign w_run      = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_ARMED);
  assign w_wrap     = w_run && (us_time < r_prev);
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_addr_max = (r_addr == {ADDR_BITS{1'b1}});
  assign w_adv      = w_push || w_skip;

`ifdef LATE_DROP_EN
  assign w_late = w_due && ((us_time - r_pend[28:0]) > LATE_WINDOW);
`else
  assign w_late = 1'b0;
`endif

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_skip = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = w_wrap ? S_DONE : S_WAIT;
      S_WAIT:         w_next = w_wrap ? S_DONE : S_ARMED;
      S_ARMED: begin
        if (w_wrap || r_pend[31]) begin
          w_next = S_DONE;
        end else if (w_late) begin
          w_skip = 1'b1;
          w_next = w_addr_max ? S_DONE : S_FETCH;
        end else if (w_due && w_room) begin
          w_push = 1'b1;
          w_next = w_addr_max ? S_DONE : S_FETCH;
        end
      end
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = w_run;
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_addr    <= '0;
      r_pend    <= '0;
      r_prev    <= '0;
      r_wrapped <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
    end else begin
      r_prev <= us_time;
      if (r_state == S_WAIT) r_pend <= rom_data;
      if (w_start) begin
        r_addr    <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_wrapped <= 1'b0;
      end else begin
        if (w_adv)  r_addr <= r_addr + ADDR_BITS'(1);
        if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
        if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
        if (w_wrap) r_wrapped <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= r_pend[30:0];
  end

`ifdef LATE_DROP_EN
  logic [7:0] r_late;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)                         r_late <= '0;
    else if (w_start)                   r_late <= '0;
    else if (w_skip && r_late != 8'hFF) r_late <= r_late + 8'd1;
  end
  assign late_count = r_late;
`else
  // The window is irrelevant without late dropping; the count is pinned to zero.
  assign late_count = 8'(LATE_WINDOW & 29'd0);
`endif

  assign w_head      = r_mem[r_rptr[PW-1:0]];
  assign ev.ev_valid = !w_empty;
  assign ev.ev_lane  = w_empty ? 2'd0  : w_head[30:29];
  assign ev.ev_time  = w_empty ? 29'd0 : w_head[28:0];
  assign rom_addr    = r_addr;
  assign wrapped     = r_wrapped;

endmodule
